sub_serial: RTL and testbench
=============================

Name: sub_serial

Overview:
- Bit-serial W-bit unsigned subtractor: computes A − B one bit per clock, LSB first, with a ripple borrow register.
- Counterpart to the team's bit-serial adder; shares its datapath style (one full-subtractor cell plus bit index).
- Adds a start/ready/done handshake so a controller can issue operations and collect results without guessing cycle counts.

Parameters:
- W, 8, operand and difference width in bits; legal range W ≥ 2.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  request a new subtraction; sampled only while ready_o=1.
- a_i  in  W  minuend; captured on the accepting edge.
- b_i  in  W  subtrahend; captured on the accepting edge.
- ready_o  out  1  high in IDLE; block can accept start_i.
- done_o  out  1  one-cycle pulse; diff_o/borrow_o valid and updated.
- diff_o  out  W  (A − B) mod 2^W; registered and held until the next completion.
- borrow_o  out  1  final borrow; 1 iff A < B (unsigned).

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, ready_o=1, done_o=0, diff_o=0, borrow_o=0.
  - Internal operand registers, borrow, bit index and partial difference all cleared.
- States:
  - IDLE: ready_o=1. When start_i=1, the edge captures a_i and b_i, sets borrow=0 and idx=0, then goes to RUN.
  - RUN: ready_o=0. Each edge processes bit idx:
    - d[idx] = a[idx] ^ b[idx] ^ br
    - br' = (~a[idx] & b[idx]) | (~(a[idx] ^ b[idx]) & br)
    - idx increments.
  - Last RUN edge (idx=W−1):
    - Writes d[W−1].
    - Loads diff_o with the full difference and borrow_o with br'.
    - Sets done_o=1 and returns to IDLE.
- Latency:
  - Accepting edge = edge 0; bit i is computed at edge i+1.
  - done_o is high in the cycle after edge W, and ready_o=1 in that same cycle.
  - A new start_i may be accepted at edge W+1, giving a throughput of one operation per W+1 cycles.
- start_i while RUN: ignored. Operands in flight are unaffected; no queuing.
- a_i/b_i changing during RUN: no effect; only the captured copies are used.
- done_o is deasserted on the edge after it rises, including when a new start is accepted on that edge.
- diff_o/borrow_o change only at completion (or reset); they are stable in all other cycles.
- Reset asserted mid-RUN: the operation is aborted, no done_o pulse, all outputs go to their reset values.
- idx counter width is $clog2(W)+1; no wrap occurs inside RUN.
- Arithmetic:
  - Pure unsigned modular; diff_o + b = a + borrow_o·2^W.
  - A = B gives diff_o=0, borrow_o=0.

Optional Feature:
- Macro: SUB_SERIAL_OVF_EN.
- Defined:
  - Adds output port ovf_o (1 bit): two's-complement overflow of A − B.
  - ovf_o = (a[W−1] ≠ b[W−1]) & (d[W−1] ≠ a[W−1]).
  - Registered with diff_o at completion; reset value 0; held like diff_o.
- Undefined: port ovf_o and its logic are absent; all other behaviour is identical.

Test Plan:
- W=8, a=0x35, b=0x12 → done_o pulse 9 cycles after the accepting edge; diff_o=0x23, borrow_o=0, ovf_o=0.
- a=0x12, b=0x35 → diff_o=0xDD, borrow_o=1; a=0x00, b=0x01 → diff_o=0xFF, borrow_o=1.
- a=0x80, b=0x01 → diff_o=0x7F, borrow_o=0, ovf_o=1 (with SUB_SERIAL_OVF_EN); a=0x5A, b=0x5A → diff_o=0x00, borrow_o=0.
- Start a=0x10, b=0x01; pulse start_i with a=0xFF, b=0x00 at cycle 3 of RUN → ignored; result is 0x0F, exactly one done_o pulse.
- Back-to-back: start_i held high continuously → operations accepted every 9 cycles; each done_o is a single cycle; diff_o holds between completions.
- Drop rst_ni at cycle 4 of RUN → outputs go to 0 immediately (asynchronously), ready_o=1, no done_o; after release, a fresh 0x35 − 0x12 returns 0x23.

Source files
------------

// File: rtl/sub_serial.sv
// sub_serial: bit-serial W-bit unsigned subtractor (A - B, LSB first) with start/ready/done handshake.
// Define SUB_SERIAL_OVF_EN to add the registered two's-complement overflow output ovf_o.
module sub_serial #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic         ovf_o
`endif
);
    localparam int IW = $clog2(W) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_br;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_d;
    logic [W-1:0]    r_diff;
    logic            r_borrow;
    logic            r_done;
    logic            w_accept;
    logic            w_last;
    logic            w_ai;
    logic            w_bi;
    logic            w_d;
    logic            w_br;
    logic [W-1:0]    w_dsh;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_accept = (r_state == IDLE) && start_i;
        w_last   = (r_state == RUN) && (r_idx == IW'(W - 1));
        w_next   = w_accept ? RUN : (w_last ? IDLE : r_state);
        ready_o  = (r_state == IDLE);
    end

    // Operands shift right each bit so the current bit is always at index 0;
    // the difference shifts in from the MSB and is fully aligned after W bits.
    always_comb begin
        w_ai  = r_a[0];
        w_bi  = r_b[0];
        w_d   = w_ai ^ w_bi ^ r_br;
        w_br  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
        w_dsh = {w_d, r_d[W-1:1]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a      <= '0;
            r_b      <= '0;
            r_br     <= 1'b0;
            r_idx    <= '0;
            r_d      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a   <= a_i;
                r_b   <= b_i;
                r_br  <= 1'b0;
                r_idx <= '0;
                r_d   <= '0;
            end else if (r_state == RUN) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_br  <= w_br;
                r_idx <= r_idx + IW'(1);
                r_d   <= w_dsh;
                if (w_last) begin
                    r_diff   <= w_dsh;
                    r_borrow <= w_br;
                end
            end
        end
    end

`ifdef SUB_SERIAL_OVF_EN
    logic r_ovf;

    // On the last bit, w_ai/w_bi/w_d are the operand and result sign bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     r_ovf <= 1'b0;
        else if (w_last) r_ovf <= (w_ai ^ w_bi) & (w_d ^ w_ai);
    end

    assign ovf_o = r_ovf;
`endif

    assign done_o   = r_done;
    assign diff_o   = r_diff;
    assign borrow_o = r_borrow;
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: scoreboard bench for sub_serial; expected results queued at issue, compared on done_o.
module tb_sub_serial;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         ready_o;
    logic         done_o;
    logic [W-1:0] diff_o;
    logic         borrow_o;
`ifdef SUB_SERIAL_OVF_EN
    logic         ovf_o;
`endif

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_done = 0;
    logic         prev_done = 1'b0;
    logic [W-1:0] last_diff = '0;
    exp_t         sb[$];

    sub_serial #(.W(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .ready_o (ready_o),
        .done_o  (done_o),
        .diff_o  (diff_o),
        .borrow_o(borrow_o)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W:0]   r;
        r    = {1'b0, a} - {1'b0, b};
        e.d  = r[W-1:0];
        e.br = r[W];
        e.ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    always @(negedge clk_i) begin
        if (done_o) begin
            n_done++;
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("spurious_done", {31'd0, done_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", {24'd0, diff_o}, {24'd0, e.d});
                check("borrow", {31'd0, borrow_o}, {31'd0, e.br});
`ifdef SUB_SERIAL_OVF_EN
                check("ovf", {31'd0, ovf_o}, {31'd0, e.ov});
`endif
                last_diff = e.d;
            end
        end
        prev_done = done_o;
    end

    task automatic wait_ready();
        int c;
        c = 0;
        @(negedge clk_i);
        while (!ready_o && c < 20) begin
            @(negedge clk_i);
            c++;
        end
        if (!ready_o) check("ready_timeout", {31'd0, ready_o}, 32'd1);
    endtask

    // Issue one op; inj>0 pulses a bogus start at that RUN cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
        int c;
        int d0;
        wait_ready();
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        sb.push_back(model(a, b));
        d0 = n_done;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        a_i = W'($urandom);
        b_i = W'($urandom);
        c = 0;
        do begin
            @(negedge clk_i);
            c++;
            start_i = (c == inj);
            if (c == inj) begin
                a_i = 8'hFF;
                b_i = 8'h00;
            end
            if (c <= W) begin
                check("ready_run", {31'd0, ready_o}, 32'd0);
                check("diff_hold", {24'd0, diff_o}, {24'd0, last_diff});
            end
        end while (!done_o && c < W + 4);
        start_i = 1'b0;
        check("latency", c, W + 1);
        check("ready_done", {31'd0, ready_o}, 32'd1);
        @(negedge clk_i);
        check("done_fall", {31'd0, done_o}, 32'd0);
        check("one_done", n_done - d0, 1);
    endtask

    task automatic b2b(input int n);
        logic [W-1:0] a;
        logic [W-1:0] b;
        @(negedge clk_i);
        a = W'($urandom);
        b = W'($urandom);
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        sb.push_back(model(a, b));
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
            if (k < n - 1) begin
                a = W'($urandom);
                b = W'($urandom);
                a_i = a;
                b_i = b;
                sb.push_back(model(a, b));
            end else begin
                start_i = 1'b0;
            end
            for (int c = 1; c <= W + 1; c++) begin
                @(negedge clk_i);
                check("b2b_done", {31'd0, done_o}, {31'd0, c == W + 1});
                check("b2b_ready", {31'd0, ready_o}, {31'd0, c == W + 1});
            end
        end
    endtask

    initial begin
        #2;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_diff", {24'd0, diff_o}, 32'd0);
        check("rst_borrow", {31'd0, borrow_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        run_op(8'h35, 8'h12, 0);
        run_op(8'h12, 8'h35, 0);
        run_op(8'h00, 8'h01, 0);
        run_op(8'h80, 8'h01, 0);
        run_op(8'h5A, 8'h5A, 0);
        run_op(8'h7F, 8'h80, 0);
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'h10, 8'h01, 3);
        for (int i = 0; i < 6; i++) run_op(W'($urandom), W'($urandom), 0);

        b2b(4);
        repeat (2) @(negedge clk_i);
        check("b2b_sb_empty", sb.size(), 0);

        // Abort mid-RUN; previous result is nonzero so the async clear is observable.
        run_op(8'h12, 8'h35, 0);
        wait_ready();
        a_i = 8'h35;
        b_i = 8'h12;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_diff", {24'd0, diff_o}, 32'd0);
        check("arst_borrow", {31'd0, borrow_o}, 32'd0);
        check("arst_ready", {31'd0, ready_o}, 32'd1);
        check("arst_done", {31'd0, done_o}, 32'd0);
`ifdef SUB_SERIAL_OVF_EN
        check("arst_ovf", {31'd0, ovf_o}, 32'd0);
`endif
        last_diff = '0;
        repeat (12) begin
            @(negedge clk_i);
            check("arst_no_done", {31'd0, done_o}, 32'd0);
        end
        rst_ni = 1'b1;
        run_op(8'h35, 8'h12, 0);

        repeat (3) @(negedge clk_i);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
